ks_sub_pipe: RTL and testbench

- Pipelined Kogge-Stone subtractor with a borrow input: diff = a - b - bin. It is the inverse-direction companion to the team's combinational Kogge-Stone adder.
- Internally it reuses the same prefix structure: pre-processing, black/grey tree rows, then post XOR. Subtraction is done as a + ~b + ~bin, and borrow-out is the inverted carry-out.
- The prefix datapath is split into three registered stages behind a valid/ready stream interface. It sits between operand-producing logic and the ALU result mux.

---
 rtl/ks_sub_pipe.sv | 148 ++++++++++++++
 tb/tb_ks_sub_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sub_pipe.sv
// ks_sub_pipe: three-stage pipelined Kogge-Stone subtractor, diff = a - b - bin.
// Works as a + ~b + ~bin on the adder prefix tree; borrow-out is the inverted carry-out.
// Bit vectors inside the tree are WIDTH+1 wide: index 0 is the carry-in
// position (bit -1), index i+1 is operand bit i.
// Optional macro KS_SUB_FLAGS_EN adds registered out_zero / out_ovf flags.
module ks_sub_pipe #(
  parameter int WIDTH      = 8,
  parameter int TREE_SPLIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
`ifdef KS_SUB_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

  localparam int ROWS = $clog2(WIDTH) + 1;

  // Applies prefix rows row_lo..row_hi to (g,p); returns group G or P.
  // A row whose left operand group already reaches bit -1 is a grey cell,
  // so its group propagate is forced to 0.
  function automatic logic [WIDTH:0] prefix_rows(
    input logic [WIDTH:0] g_in,
    input logic [WIDTH:0] p_in,
    input int             row_lo,
    input int             row_hi,
    input logic           sel_p
  );
    logic [WIDTH:0] g;
    logic [WIDTH:0] p;
    int             d;
    g = g_in;
    p = p_in;
    for (int k = 1; k <= ROWS; k++) begin
      if (k >= row_lo && k <= row_hi) begin
        d = 1 << (k - 1);
        // descending order keeps g[j-d]/p[j-d] at their previous-row values
        for (int j = WIDTH; j >= 0; j--) begin
          if (j >= d) begin
            g[j] = g[j] | (p[j] & g[j-d]);
            p[j] = (j < 2 * d) ? 1'b0 : (p[j] & p[j-d]);
          end
        end
      end
    end
    return sel_p ? p : g;
  endfunction

  logic             v1, v2, v3;
  logic             adv1, adv2, adv3;
  logic [WIDTH:0]   s1_g, s1_p;
  logic [WIDTH:0]   s2_g, s2_p;
  logic [WIDTH-1:0] s2_pb;
  logic [WIDTH:0]   gc;
  logic [WIDTH-1:0] diff_n;
  logic             bout_n;

  assign adv3      = !v3 | out_ready;
  assign adv2      = !v2 | adv3;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  assign gc     = prefix_rows(s2_g, s2_p, TREE_SPLIT + 1, ROWS, 1'b0);
  assign diff_n = s2_pb ^ gc[WIDTH-1:0];
  assign bout_n = ~gc[WIDTH];

`ifdef KS_SUB_FLAGS_EN
  logic s1_amsb, s1_bmsb, s2_amsb, s2_bmsb;
`endif

  // Stage 1: register pre-processed (g,p) with the inverted borrow as carry-in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1_g <= '0;
      s1_p <= '0;
`ifdef KS_SUB_FLAGS_EN
      s1_amsb <= 1'b0;
      s1_bmsb <= 1'b0;
`endif
    end else if (adv1) begin
      v1   <= in_valid;
      s1_g <= {in_a & ~in_b, ~in_bin};
      s1_p <= {in_a ^ ~in_b, 1'b0};
`ifdef KS_SUB_FLAGS_EN
      s1_amsb <= in_a[WIDTH-1];
      s1_bmsb <= in_b[WIDTH-1];
`endif
    end
  end

  // Stage 2: register group (G,P) after the first TREE_SPLIT prefix rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      s2_g  <= '0;
      s2_p  <= '0;
      s2_pb <= '0;
`ifdef KS_SUB_FLAGS_EN
      s2_amsb <= 1'b0;
      s2_bmsb <= 1'b0;
`endif
    end else if (adv2) begin
      v2    <= v1;
      s2_g  <= prefix_rows(s1_g, s1_p, 1, TREE_SPLIT, 1'b0);
      s2_p  <= prefix_rows(s1_g, s1_p, 1, TREE_SPLIT, 1'b1);
      s2_pb <= s1_p[WIDTH:1];
`ifdef KS_SUB_FLAGS_EN
      s2_amsb <= s1_amsb;
      s2_bmsb <= s1_bmsb;
`endif
    end
  end

  // Stage 3: finish the tree, post-XOR, and hold the result while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3       <= 1'b0;
      out_diff <= '0;
      out_bout <= 1'b0;
`ifdef KS_SUB_FLAGS_EN
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
`endif
    end else if (adv3) begin
      v3       <= v2;
      out_diff <= diff_n;
      out_bout <= bout_n;
`ifdef KS_SUB_FLAGS_EN
      out_zero <= (diff_n == '0);
      out_ovf  <= (s2_amsb != s2_bmsb) & (diff_n[WIDTH-1] != s2_amsb);
`endif
    end
  end

endmodule

// File: tb/tb_ks_sub_pipe.sv
// tb_ks_sub_pipe: checks ks_sub_pipe (WIDTH=8) against an arithmetic reference
// queue, plus directed literal expectations for latency, stall, reset and flags.
module tb_ks_sub_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_diff;
  logic       out_bout;
`ifdef KS_SUB_FLAGS_EN
  logic       out_zero;
  logic       out_ovf;
`endif

  ks_sub_pipe #(.WIDTH(8), .TREE_SPLIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout)
`ifdef KS_SUB_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       ov;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_d[$];
  logic       got_b[$];
  logic       got_z[$];
  logic       got_o[$];
  int         got_cyc[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_acc = 0;
  int         cyc = 0;
  logic       have_prev = 1'b0;
  logic       prev_valid, prev_ready, prev_bout;
  logic [7:0] prev_diff;
  exp_t       mon_e;

  logic [7:0] a3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] b3 [5] = '{8'h03, 8'h30, 8'h33, 8'h10, 8'h66};
  logic [4:0] bin3 = 5'b01010;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int   r;
    exp_t e;
    r    = int'(a) - int'(b) - int'(bin);
    e.d  = r[7:0];
    e.bo = (r < 0);
    e.z  = (e.d == 8'h00);
    e.ov = (a[7] != b[7]) && (e.d[7] != a[7]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_d.delete();
    got_b.delete();
    got_z.delete();
    got_o.delete();
    got_cyc.delete();
  endtask

  // present one beat and hold it until it is accepted
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic acc;
    int   t;
    in_a = a;
    in_b = b;
    in_bin = bin;
    in_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) timeout_fail("send_accept");
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // compare process: ordering, values, in_ready occupancy rule and stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_valid && !prev_ready) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_diff", 32'(out_diff), 32'(prev_diff));
        chk("stall_bout", 32'(out_bout), 32'(prev_bout));
      end
      chk("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 3 && !out_ready)));
      if (exp_q.size() == 0) chk("idle_valid", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got diff 0x%0h with nothing outstanding (cycle %0d)", out_diff, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("diff", 32'(out_diff), 32'(mon_e.d));
          chk("bout", 32'(out_bout), 32'(mon_e.bo));
`ifdef KS_SUB_FLAGS_EN
          chk("zero", 32'(out_zero), 32'(mon_e.z));
          chk("ovf", 32'(out_ovf), 32'(mon_e.ov));
          got_z.push_back(out_zero);
          got_o.push_back(out_ovf);
`else
          got_z.push_back(1'b0);
          got_o.push_back(1'b0);
`endif
          got_d.push_back(out_diff);
          got_b.push_back(out_bout);
          got_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_bin));
        n_acc++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_diff  = out_diff;
      prev_bout  = out_bout;
      have_prev  = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nacc;
    int   start;
    int   t;
    logic rd;
    logic rdy3;

    // reset state
    wait_cycles(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(out_diff), 32'd0);
    chk("rst_bout", 32'(out_bout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef KS_SUB_FLAGS_EN
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
`endif
    @(posedge clk);
    #1;

    // single beat latency
    out_ready = 1'b1;
    send(8'h50, 8'h20, 1'b0);
    @(negedge clk);
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge3_valid", 32'(out_valid), 32'd1);
    chk("lat_diff", 32'(out_diff), 32'h30);
    chk("lat_bout", 32'(out_bout), 32'd0);
    wait_cycles(3);

    // back-to-back beats
    clear_log();
    send(8'h00, 8'h01, 1'b0);
    send(8'h05, 8'h05, 1'b1);
    send(8'hFF, 8'h00, 1'b1);
    wait_cycles(6);
    chk("b2b_count", 32'(got_d.size()), 32'd3);
    if (got_d.size() == 3) begin
      chk("b2b_d0", 32'(got_d[0]), 32'hFF);
      chk("b2b_b0", 32'(got_b[0]), 32'd1);
      chk("b2b_d1", 32'(got_d[1]), 32'hFF);
      chk("b2b_b1", 32'(got_b[1]), 32'd1);
      chk("b2b_d2", 32'(got_d[2]), 32'hFE);
      chk("b2b_b2", 32'(got_b[2]), 32'd0);
      chk("b2b_gap1", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
      chk("b2b_gap2", 32'(got_cyc[2] - got_cyc[1]), 32'd1);
    end

    // boundary operands
    clear_log();
    send(8'h00, 8'hFF, 1'b1);
    send(8'hA5, 8'hA5, 1'b0);
    wait_cycles(6);
    chk("bnd_count", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("bnd_d0", 32'(got_d[0]), 32'h00);
      chk("bnd_b0", 32'(got_b[0]), 32'd1);
      chk("bnd_d1", 32'(got_d[1]), 32'h00);
      chk("bnd_b1", 32'(got_b[1]), 32'd0);
    end

    // fill under backpressure, then release
    clear_log();
    out_ready = 1'b0;
    nacc = 0;
    rdy3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_a = a3[nacc];
      in_b = b3[nacc];
      in_bin = bin3[nacc];
      @(negedge clk);
      rd = in_ready;
      if (c == 3) rdy3 = rd;
      @(posedge clk);
      #1;
      if (rd) nacc++;
    end
    chk("fill_accepted", 32'(nacc), 32'd3);
    chk("fill_ready_c3", 32'(rdy3), 32'd0);
    chk("fill_out_valid", 32'(out_valid), 32'd1);
    chk("fill_out_diff", 32'(out_diff), 32'h0E);
    out_ready = 1'b1;
    for (int k = 3; k < 5; k++) send(a3[k], b3[k], bin3[k]);
    wait_cycles(8);
    chk("drain_count", 32'(got_d.size()), 32'd5);
    if (got_d.size() == 5) begin
      chk("drain_first", 32'(got_d[0]), 32'h0E);
      for (int k = 1; k < 5; k++) chk("drain_gap", 32'(got_cyc[k] - got_cyc[k-1]), 32'd1);
    end

    // reset with three beats in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(a3[k], b3[k], bin3[k]);
    clear_log();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_diff", 32'(out_diff), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_cycles(6);
    chk("mrst_no_stale", 32'(got_d.size()), 32'd0);

`ifdef KS_SUB_FLAGS_EN
    // flags
    clear_log();
    send(8'h80, 8'h01, 1'b0);
    send(8'h42, 8'h42, 1'b0);
    wait_cycles(6);
    chk("flg_count", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("flg_d0", 32'(got_d[0]), 32'h7F);
      chk("flg_o0", 32'(got_o[0]), 32'd1);
      chk("flg_z0", 32'(got_z[0]), 32'd0);
      chk("flg_d1", 32'(got_d[1]), 32'h00);
      chk("flg_z1", 32'(got_z[1]), 32'd1);
      chk("flg_o1", 32'(got_o[1]), 32'd0);
    end
`endif

    // random traffic
    start = n_acc;
    t = 0;
    while ((n_acc - start) < 2000 && t < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_bin    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      t++;
    end
    if ((n_acc - start) < 2000) timeout_fail("random_accepts");
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
